// File: rtl/one_two_demux_pkg.sv
// rtl/one_two_demux_pkg.sv - shared slot state encoding and default widths for one_two_demux
package one_two_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_CNT_WIDTH = 8;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry destination slot with data register and delivery counter
module demux_slot
  import one_two_demux_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_ready,
  output logic                 can_accept,
  output logic                 valid,
  output logic [WORD_SIZE-1:0] data,
  output logic [CNT_WIDTH-1:0] count
);

  slot_state_e          state_q, state_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 rd_fire;

  // Next slot state: a write always wins (fill or refill), a lone read drains the slot
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    rd_fire = (state_q == SLOT_FULL) && rd_ready;
    if (rd_fire) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
    if (wr_en) begin
      state_d = SLOT_FULL;
      data_d  = wr_data;
    end else if (rd_fire) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot registers; reset drops any held word and suppresses that cycle's count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Slot can take a word if empty, or if the held word leaves this same cycle
  always_comb begin
    can_accept = (state_q == SLOT_EMPTY) || rd_ready;
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;
  assign count = count_q;

endmodule

// File: rtl/one_two_demux.sv
// rtl/one_two_demux.sv - one-input two-output demultiplexer with per-destination one-entry slots
module one_two_demux
  import one_two_demux_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] out0_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [CNT_WIDTH-1:0] out0_count,
  output logic [WORD_SIZE-1:0] out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [CNT_WIDTH-1:0] out1_count,
  output logic                 busy
);

  logic acc0, acc1;
  logic wr0, wr1;

  // Readiness looks only at the selected slot so a stalled other destination never blocks
  always_comb begin
    in_ready = rst_n && (in_sel ? acc1 : acc0);
    wr0      = in_valid && in_ready && !in_sel;
    wr1      = in_valid && in_ready && in_sel;
  end

  demux_slot #(
    .WORD_SIZE(WORD_SIZE),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr0),
    .wr_data   (in_data),
    .rd_ready  (out0_ready),
    .can_accept(acc0),
    .valid     (out0_valid),
    .data      (out0_data),
    .count     (out0_count)
  );

  demux_slot #(
    .WORD_SIZE(WORD_SIZE),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr1),
    .wr_data   (in_data),
    .rd_ready  (out1_ready),
    .can_accept(acc1),
    .valid     (out1_valid),
    .data      (out1_data),
    .count     (out1_count)
  );

  assign busy = out0_valid || out1_valid;

endmodule
